// File: rtl/fault_supervisor.sv
// fault_supervisor: persistence-filtered fault trip latch with operator clear, re-arm hold-off and trip counter
module fault_supervisor #(
  parameter int PERSIST = 4,
  parameter int HOLDOFF = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [2:0]       fault_type,
  input  logic             clear_req,
  output logic             trip,
  output logic [2:0]       latched_fault,
  output logic             motor_enable,
  output logic             clear_ack,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] fault_count
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PENDING = 2'b01, S_TRIPPED = 2'b10, S_HOLD = 2'b11} state_t;
  state_t           r_state, w_state;
  logic [7:0]       r_hcnt, w_hcnt;
  logic [2:0]       r_cand, w_cand, w_latched;
  logic [3:0]       r_pcnt, w_pcnt;
  logic             w_ack, w_entry;
  logic [CNT_W-1:0] w_cnt;
  assign state = r_state;
  // next state, persistence tracking, escalation and trip bookkeeping
  always_comb begin
    w_state   = r_state;
    w_hcnt    = r_hcnt;
    w_cand    = r_cand;
    w_pcnt    = r_pcnt;
    w_latched = latched_fault;
    w_ack     = 1'b0;
    w_cnt     = fault_count;
    case (r_state)
      S_IDLE: if (sample_valid && fault_type != 3'b000) begin
        w_cand  = fault_type;
        w_pcnt  = 4'd1;
        w_state = (PERSIST == 1) ? S_TRIPPED : S_PENDING;
      end
      S_PENDING: if (sample_valid) begin
        if (fault_type == 3'b000) begin
          w_state = S_IDLE;
          w_pcnt  = '0;
        end else if (fault_type == r_cand) begin
          w_pcnt  = r_pcnt + 4'd1;
          w_state = (w_pcnt == 4'(PERSIST)) ? S_TRIPPED : S_PENDING;
        end else begin
          w_cand = fault_type;
          w_pcnt = 4'd1;
        end
      end
      S_TRIPPED: if (clear_req) begin
        w_state   = S_HOLD;
        w_hcnt    = '0;
        w_ack     = 1'b1;
        w_latched = 3'b000;
      end else if (sample_valid && fault_type > latched_fault) begin
        w_latched = fault_type;
      end
      default: begin
        w_cand  = '0;
        w_pcnt  = '0;
        w_state = (r_hcnt == 8'(HOLDOFF - 1)) ? S_IDLE : S_HOLD;
        w_hcnt  = (r_hcnt == 8'(HOLDOFF - 1)) ? r_hcnt : r_hcnt + 8'd1;
      end
    endcase
    w_entry = (w_state == S_TRIPPED) && (r_state != S_TRIPPED);
    if (w_entry) begin
      w_latched = w_cand;
      w_cnt     = (&fault_count) ? fault_count : fault_count + CNT_W'(1);
      w_pcnt    = '0;
    end
  end
  // register state and all outputs so each reflects the state entered at this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HOLD;
      r_hcnt        <= '0;
      r_cand        <= '0;
      r_pcnt        <= '0;
      trip          <= 1'b0;
      latched_fault <= 3'b000;
      motor_enable  <= 1'b0;
      clear_ack     <= 1'b0;
      fault_count   <= '0;
    end else begin
      r_state       <= w_state;
      r_hcnt        <= w_hcnt;
      r_cand        <= w_cand;
      r_pcnt        <= w_pcnt;
      trip          <= (w_state == S_TRIPPED);
      latched_fault <= w_latched;
      motor_enable  <= (w_state == S_IDLE) || (w_state == S_PENDING);
      clear_ack     <= w_ack;
      fault_count   <= w_cnt;
    end
  end
endmodule

// File: doc/fault_supervisor.md
Name: fault_supervisor

Overview:
- Sits directly downstream of the combinational fault classifier and consumes its 3-bit fault_type code on each sample strobe.
- Requires a fault code to persist for PERSIST consecutive valid samples, then trips and latches the fault. Severity escalation is allowed while tripped.
- Holds the motor disabled until an operator clear request, then waits a re-arm hold-off.
- Keeps a saturating trip counter for the diagnostics readout.

Parameters:
- PERSIST, 4: consecutive valid samples of the same nonzero code required to trip. Legal range 1..15.
- HOLDOFF, 8: clock cycles spent in HOLDOFF after a clear, and after reset, before monitoring resumes. Legal range 1..255.
- CNT_W, 8: width of fault_count.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- sample_valid, input, 1: fault_type is valid this cycle.
- fault_type, input, 3: classifier code. 000 none, 001 rotor, 010 stator, 011 vibration, 100 undervoltage. A larger code means more severe.
- clear_req, input, 1: operator clear, level or pulse.
- trip, output, 1: fault latched.
- latched_fault, output, 3: latched fault code; 000 when not tripped.
- motor_enable, output, 1: drive permitted.
- clear_ack, output, 1: one-cycle pulse when a clear is accepted.
- state, output, 2: IDLE=00, PENDING=01, TRIPPED=10, HOLDOFF=11.
- fault_count, output, CNT_W: number of entries to TRIPPED, saturating.

Behaviour:
- All outputs are registered. Each reflects the state entered at the same clock edge (one-cycle latency from a sampled input).
- Inputs are ignored when sample_valid=0, except clear_req. Candidate code and persistence counter hold their values.

Reset (asynchronous, rst=1):
- state=HOLDOFF, holdoff counter=0.
- trip=0, latched_fault=000, motor_enable=0, clear_ack=0, fault_count=0.
- Internal candidate code=000, persistence counter=0.

IDLE:
- motor_enable=1.
- sample_valid and fault_type!=000: candidate=fault_type, pcnt=1, go to PENDING. If PERSIST==1, go directly to TRIPPED instead.

PENDING:
- motor_enable=1.
- sample_valid and fault_type==candidate: pcnt+1. When pcnt+1==PERSIST, go to TRIPPED.
- sample_valid and fault_type==000: go to IDLE, pcnt=0.
- sample_valid and a different nonzero code: candidate=new code, pcnt=1, stay in PENDING.

Entry to TRIPPED:
- trip=1, motor_enable=0, latched_fault=candidate.
- fault_count increments by 1, saturating at all-ones.

TRIPPED:
- Escalation: sample_valid and fault_type>latched_fault sets latched_fault=fault_type immediately, with no persistence. fault_count does not increment and the state does not change.
- Lower or zero codes are ignored.
- clear_req=1: clear_ack=1 for exactly one cycle, go to HOLDOFF. Holdoff counter=0, trip=0, latched_fault=000.
- clear_req takes priority over escalation in the same cycle.

HOLDOFF:
- motor_enable=0. All fault samples are ignored.
- The counter increments every clock. When it reaches HOLDOFF-1, go to IDLE; motor_enable=1 on that edge.
- Candidate code and pcnt are cleared.

clear_req outside TRIPPED:
- Ignored; clear_ack stays 0.
- A clear_req held high does not re-acknowledge, because TRIPPED is re-entered only via a new fault sequence.

rst asserted mid-operation from any state:
- Immediately forces the reset values above, including losing a latched fault.
- The motor stays disabled for HOLDOFF cycles after rst deasserts.

Test Plan:
- Reset released with sample_valid=0 -> state=11, motor_enable=0 for 8 cycles, then state=00, motor_enable=1, fault_count=0.
- In IDLE, four consecutive valid samples of 010 -> state goes 01, 01, 01, then 10 on the 4th sample edge. trip=1, latched_fault=010, motor_enable=0, fault_count=1.
- Valid samples 001, 001, 000, 001, 001, 001 -> no trip. Return to IDLE after the 000, trip on the 4th 001 of the second run.
- Valid samples 011, 011, 001 -> candidate restarts to 001 with pcnt=1. Three more 001 samples are then needed to trip with latched_fault=001.
- While tripped with 010, one valid sample of 100 -> latched_fault=100 next cycle, fault_count unchanged. A following 001 leaves latched_fault at 100.
- clear_req pulse in TRIPPED, coincident with a valid 100 sample -> clear_ack single pulse, state=11, latched_fault=000, IDLE after 8 cycles. clear_req held during IDLE gives no clear_ack. 255 trip cycles with CNT_W=8 leave fault_count=255.
